// File: rtl/data_mem_sized.sv
// Multi-cycle byte/half/word data memory with a req/ready handshake and WAIT_STATES wait cycles.
// Optional misaligned-access trap is enabled by defining DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_sized #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_read_data;
  logic              r_ready;
  logic              r_busy;
  logic              r_misaligned;
  logic [31:0]       r_mem [0:DEPTH-1] = '{default: 32'h0};

  logic              w_is_half;
  logic              w_is_word;
  logic              w_err;
  logic [1:0]        w_lane_off;
  logic [ADDR_W-1:0] w_word_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_rword;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_val;
  logic              w_access;
  logic              w_do_store;
  logic              w_do_load;
  logic              w_unused_addr;

  // Upper address bits are intentionally ignored so the address wraps.
  assign w_unused_addr = ^alu_result[31:ADDR_W+2];

  assign w_is_word  = r_size[1];
  assign w_is_half  = (r_size == 2'b01);
  assign w_word_idx = r_addr[ADDR_W+1:2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign w_err      = (w_is_half && r_addr[0]) || (w_is_word && (r_addr[1:0] != 2'b00));
  assign w_lane_off = r_addr[1:0];
`else
  assign w_err      = 1'b0;
  assign w_lane_off = w_is_word ? 2'b00 : (w_is_half ? {r_addr[1], 1'b0} : r_addr[1:0]);
`endif

  // A reset on the completion edge wins, so an aborted store never lands.
  assign w_access   = (r_state == S_DONE) && !reset && !w_err;
  assign w_do_store = w_access && r_write;
  assign w_do_load  = w_access && !r_write;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign w_be[gi] = w_is_word || (w_is_half ? (LANE[1] == w_lane_off[1]) : (LANE == w_lane_off));
    assign w_wlanes[8*gi +: 8] = w_is_word ? r_wdata[8*gi +: 8] :
                                 (w_is_half ? r_wdata[8*(gi%2) +: 8] : r_wdata[7:0]);
  end

  always_ff @(posedge clk) begin
    if (w_do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_word_idx];
  assign w_byte  = w_rword[{w_lane_off, 3'b000} +: 8];
  assign w_half  = w_rword[{w_lane_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = w_rword;
    case (r_size)
      2'b00:   w_load_val = {{24{!r_unsigned && w_byte[7]}}, w_byte};
      2'b01:   w_load_val = {{16{!r_unsigned && w_half[15]}}, w_half};
      default: w_load_val = w_rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_read_data  <= 32'h0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_ready      <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (req) begin
            r_write    <= mem_write;
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_addr     <= alu_result[ADDR_W+1:0];
            r_wdata    <= write_data;
            r_cnt      <= 4'(WAIT_STATES);
            r_busy     <= 1'b1;
            r_state    <= (WAIT_STATES > 0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready      <= 1'b1;
          r_misaligned <= w_err;
          if (w_do_load) r_read_data <= w_load_val;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_data  = r_read_data;
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_data_mem_sized.sv
// Randomized self-checking bench for data_mem_sized against a byte-array reference model.
// Follows DATA_MEM_MISALIGN_TRAP_EN the same way as the design.
module tb_data_mem_sized;
  localparam int AW = 4;
  localparam int WS = 2;
  localparam int NB = 4 * (2**AW);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_result, write_data, read_data;
  logic        ready, busy, misaligned;

  logic        req_b, mem_write_b, mem_unsigned_b;
  logic [1:0]  mem_size_b;
  logic [31:0] alu_result_b, write_data_b, read_data_b;
  logic        ready_b, busy_b, misaligned_b;

  data_mem_sized #(.ADDR_W(AW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_result(alu_result), .write_data(write_data),
    .read_data(read_data), .ready(ready), .busy(busy), .misaligned(misaligned)
  );

  data_mem_sized #(.ADDR_W(AW), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .mem_write(mem_write_b), .mem_size(mem_size_b),
    .mem_unsigned(mem_unsigned_b), .alu_result(alu_result_b), .write_data(write_data_b),
    .read_data(read_data_b), .ready(ready_b), .busy(busy_b), .misaligned(misaligned_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  model_mem [NB];
  logic [31:0] model_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  // One complete access on the WAIT_STATES=2 instance, checked against the byte model.
  task automatic access(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n, base, lat;
    bit mis, exp_mis;
    logic [31:0] v;
    n       = nbytes(sz);
    mis     = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    exp_mis = TRAP && mis;
    base    = int'(addr[AW+1:0]) & ~(n - 1);
    if (!exp_mis) begin
      if (wr) begin
        for (int i = 0; i < n; i++) model_mem[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[base + i];
        if (n < 4 && !uns && v[8*n-1]) begin
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        model_rd = v;
      end
    end

    @(negedge clk);
    req = 1'b1; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = addr; write_data = wd;
    @(posedge clk); #1;
    req = 1'b0;
    alu_result = $urandom; write_data = $urandom;
    mem_size = 2'($urandom_range(0, 3)); mem_write = 1'($urandom_range(0, 1));
    check("busy_after_capture", 32'(busy), 32'd1);

    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready) break;
      req = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    check("latency", 32'(lat), 32'(WS + 1));
    check("busy_in_ready_cycle", 32'(busy), 32'd1);
    check("misaligned", 32'(misaligned), 32'(exp_mis));
    check("read_data", read_data, model_rd);
    $display("access wr=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> read_data=%08h mis=%0d lat=%0d",
             wr, sz, uns, addr, wd, read_data, misaligned, lat);

    @(posedge clk); #1;
    check("ready_drops", 32'(ready), 32'd0);
    check("busy_drops", 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < NB; i++) model_mem[i] = 8'h00;
    model_rd = 32'h0;
    reset = 1'b1;
    req = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    alu_result = 32'h0; write_data = 32'h0;
    req_b = 1'b0; mem_write_b = 1'b0; mem_size_b = 2'b10; mem_unsigned_b = 1'b0;
    alu_result_b = 32'h0; write_data_b = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_b_ready", 32'(ready_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed sequence from the bring-up scenarios.
    access(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56AA);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'hFFFF_1234);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    access(1'b0, 2'b11, 1'b0, 32'hFFFF_FFC4, 32'h0);

    // Reset in the middle of a store: nothing must be committed.
    @(negedge clk);
    req = 1'b1; mem_write = 1'b1; mem_size = 2'b10; alu_result = 32'h8; write_data = 32'hCAFEBABE;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_rd = 32'h0;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_read_data", read_data, 32'h0);
    check("abort_misaligned", 32'(misaligned), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_ready", 32'(ready), 32'd0);
    end
    access(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);

    // Misaligned word load.
    access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0005, 32'h0);

    // Randomized traffic across the whole (small) memory, with address wrap.
    for (int t = 0; t < 200; t++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom);
    end

    // Zero-wait-state instance with req held high: one completion every two cycles.
    @(negedge clk);
    req_b = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("b2b_ready", 32'(ready_b), 32'(k % 2));
      check("b2b_busy", 32'(busy_b), 32'd1);
      if (ready_b) begin
        pulses++;
        check("b2b_read_data", read_data_b, 32'h0);
      end
    end
    req_b = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd10);
    $display("back-to-back zero-wait run: %0d completions in 20 cycles", pulses);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
